// File: rtl/pc_unit.sv
// Program counter unit: next-PC selection with exception/eret handling
// and a circular return-address stack for call/ret prediction.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
    parameter int unsigned      INC          = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_target,
    input  logic             exception,
    input  logic             eret,
    output logic [WIDTH-1:0] PC_o,
    output logic [WIDTH-1:0] EPC_o,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ret_miss
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;       // next free slot; top-1 holds the newest entry
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] epc_nxt;
    logic             miss_nxt;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] pc_seq;
    logic [PTR_W-1:0] top_m1;

    assign pc_seq    = PC_o + WIDTH'(INC);
    assign top_m1    = PTR_W'(top - PTR_W'(1));
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_W'(RAS_DEPTH));

    // Next-PC priority select; exceptions bypass the stall, everything else obeys it
    always_comb begin
        pc_nxt   = PC_o;
        epc_nxt  = EPC_o;
        miss_nxt = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        if (exception) begin
            epc_nxt = PC_o;
            pc_nxt  = EXC_VECTOR;
        end else if (PCWrite) begin
            if (eret) begin
                pc_nxt = EPC_o;
            end else if (ret) begin
                if (ras_empty) begin
                    pc_nxt   = ret_target;
                    miss_nxt = 1'b1;
                end else begin
                    pc_nxt = ras_mem[top_m1];
                    pop    = 1'b1;
                end
            end else if (call) begin
                pc_nxt = jump_target;
                push   = 1'b1;
            end else if (jump) begin
                pc_nxt = jump_target;
            end else if (branch_taken) begin
                pc_nxt = branch_target;
            end else begin
                pc_nxt = pc_seq;
            end
        end
    end

    // PC, EPC, miss flag and RAS bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC_o     <= RESET_VECTOR;
            EPC_o    <= '0;
            ret_miss <= 1'b0;
            top      <= '0;
            count    <= '0;
        end else begin
            PC_o     <= pc_nxt;
            EPC_o    <= epc_nxt;
            ret_miss <= miss_nxt;
            if (push) begin
                top <= PTR_W'(top + PTR_W'(1));
                if (!ras_full) begin
                    count <= CNT_W'(count + CNT_W'(1));
                end
            end else if (pop) begin
                top   <= top_m1;
                count <= CNT_W'(count - CNT_W'(1));
            end
        end
    end

    // RAS storage; a push into a full stack overwrites the oldest slot
    always_ff @(posedge clk) begin
        if (reset && push) begin
            ras_mem[top] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        call;
    logic        ret;
    logic [31:0] ret_target;
    logic        exception;
    logic        eret;
    logic [31:0] PC_o;
    logic [31:0] EPC_o;
    logic        ras_empty;
    logic        ras_full;
    logic        ret_miss;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_miss;
    logic [31:0] m_stack[$];

    pc_unit dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .call(call),
        .ret(ret), .ret_target(ret_target), .exception(exception),
        .eret(eret), .PC_o(PC_o), .EPC_o(EPC_o),
        .ras_empty(ras_empty), .ras_full(ras_full), .ret_miss(ret_miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_epc  = 32'h0;
        m_miss = 1'b0;
        m_stack.delete();
    endtask

    // Compare every observable output against the model
    task automatic compare_all();
        check("pc",    PC_o,      m_pc);
        check("epc",   EPC_o,     m_epc);
        check("miss",  32'(ret_miss),  32'(m_miss));
        check("empty", 32'(ras_empty), 32'(m_stack.size() == 0));
        check("full",  32'(ras_full),  32'(m_stack.size() == 4));
    endtask

    task automatic idle();
        PCWrite = 1'b1; branch_taken = 1'b0; jump = 1'b0; call = 1'b0;
        ret = 1'b0; exception = 1'b0; eret = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0; ret_target = 32'h0;
    endtask

    // Advance one clock: model computes next state from current inputs, then compare
    task automatic step();
        logic [31:0] nxt;
        nxt    = m_pc;
        m_miss = 1'b0;
        if (exception) begin
            m_epc = m_pc;
            nxt   = 32'h80;
        end else if (PCWrite) begin
            if (eret)
                nxt = m_epc;
            else if (ret) begin
                if (m_stack.size() > 0) nxt = m_stack.pop_back();
                else begin
                    nxt    = ret_target;
                    m_miss = 1'b1;
                end
            end else if (call) begin
                m_stack.push_back(m_pc + 32'd4);
                if (m_stack.size() > 4) m_stack.delete(0);
                nxt = jump_target;
            end else if (jump)
                nxt = jump_target;
            else if (branch_taken)
                nxt = branch_target;
            else
                nxt = m_pc + 32'd4;
        end
        m_pc = nxt;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_call(input logic [31:0] tgt);
        idle(); call = 1'b1; jump_target = tgt; step(); idle();
    endtask

    task automatic do_ret(input logic [31:0] fallback);
        idle(); ret = 1'b1; ret_target = fallback; step(); idle();
    endtask

    task automatic do_jump(input logic [31:0] tgt);
        idle(); jump = 1'b1; jump_target = tgt; step(); idle();
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC;
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    initial begin
        idle();
        reset = 1'b0;
        model_reset();
        #3;
        check("reset_pc_async", PC_o, 32'h0);
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // Sequential fetch from reset vector
        step(); check("seq4",  PC_o, 32'h4);
        step(); check("seq8",  PC_o, 32'h8);
        step(); check("seq12", PC_o, 32'hC);
        step(); check("seq16", PC_o, 32'h10);

        // Single call/return pair
        do_call(32'h100);
        check("call_pc", PC_o, 32'h100);
        check("call_nonempty", 32'(ras_empty), 32'h0);
        do_ret(32'h0);
        check("ret_pc", PC_o, 32'h14);
        check("ret_empty", 32'(ras_empty), 32'h1);
        check("ret_hit_nomiss", 32'(ret_miss), 32'h0);

        // Overflowing the RAS, then draining past empty
        do_jump(32'h0);
        do_call(32'h100);
        do_call(32'h200);
        do_call(32'h300);
        do_call(32'h400);
        check("full_after_4", 32'(ras_full), 32'h1);
        do_call(32'h500);
        check("full_after_5", 32'(ras_full), 32'h1);
        do_ret(32'hDEAD0); check("r1", PC_o, 32'h404);
        do_ret(32'hDEAD0); check("r2", PC_o, 32'h304);
        do_ret(32'hDEAD0); check("r3", PC_o, 32'h204);
        do_ret(32'hDEAD0); check("r4", PC_o, 32'h104);
        check("r4_empty", 32'(ras_empty), 32'h1);
        do_ret(32'hDEAD0); check("r5", PC_o, 32'hDEAD0);
        check("r5_miss", 32'(ret_miss), 32'h1);
        step(); check("miss_one_cycle", 32'(ret_miss), 32'h0);

        // Exception under stall, then eret
        do_jump(32'h40);
        idle(); PCWrite = 1'b0; exception = 1'b1; step(); idle();
        check("exc_pc", PC_o, 32'h80);
        check("exc_epc", EPC_o, 32'h40);
        idle(); eret = 1'b1; step(); idle();
        check("eret_pc", PC_o, 32'h40);
        check("eret_epc", EPC_o, 32'h40);

        // Stall with no exception holds everything
        idle(); PCWrite = 1'b0; call = 1'b1; jump_target = 32'h999; step(); idle();
        check("stall_pc", PC_o, 32'h40);
        check("stall_empty", 32'(ras_empty), 32'h1);

        // Losing events cause no RAS side effects
        do_call(32'h100);
        idle(); exception = 1'b1; call = 1'b1; ret = 1'b1; branch_taken = 1'b1;
        jump_target = 32'h700; branch_target = 32'h800; step(); idle();
        check("prio_pc", PC_o, 32'h80);
        check("prio_nonempty", 32'(ras_empty), 32'h0);
        do_ret(32'h0);
        check("prio_ret", PC_o, 32'h44);
        check("prio_empty", 32'(ras_empty), 32'h1);

        // Wraparound of PC+INC
        do_jump(32'hFFFF_FFFC);
        step(); check("wrap", PC_o, 32'h0);

        // Asynchronous reset between edges during a call
        do_jump(32'h200);
        do_call(32'h300);
        idle(); call = 1'b1; jump_target = 32'h600;
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("areset_pc", PC_o, 32'h0);
        check("areset_empty", 32'(ras_empty), 32'h1);
        @(posedge clk); #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
        idle();
        step(); check("resume", PC_o, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            PCWrite       = ($urandom_range(0, 5) != 0);
            exception     = ($urandom_range(0, 19) == 0);
            eret          = ($urandom_range(0, 15) == 0);
            ret           = ($urandom_range(0, 4) == 0);
            call          = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = rand_addr();
            jump_target   = rand_addr();
            ret_target    = rand_addr();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning PC/address width in bits.
REQ-002 SHALL provide parameter RESET_VECTOR, default 0, meaning the PC value after reset.
REQ-003 SHALL provide parameter EXC_VECTOR, default 32'h0000_0080, meaning the exception handler entry address.
REQ-004 SHALL provide parameter INC, default 4, meaning the sequential PC increment.
REQ-005 SHALL provide parameter RAS_DEPTH, default 4, meaning return-address-stack entries; legal values are powers of 2 that are >= 2.
REQ-006 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-008 SHALL have port PCWrite, input, 1, PC update enable; 0 = stall.
REQ-009 SHALL have ports branch_taken, input, 1, and branch_target, input, WIDTH.
REQ-010 SHALL have ports jump, input, 1, and jump_target, input, WIDTH.
REQ-011 SHALL have port call, input, 1, meaning jump to jump_target and push PC+INC.
REQ-012 SHALL have ports ret, input, 1, and ret_target, input, WIDTH; ret_target is the register-file fallback return address.
REQ-013 SHALL have ports exception, input, 1, and eret, input, 1.
REQ-014 SHALL have port PC_o, output, WIDTH, current PC.
REQ-015 SHALL have port EPC_o, output, WIDTH, saved exception PC.
REQ-016 SHALL have ports ras_empty, output, 1, and ras_full, output, 1.
REQ-017 SHALL have port ret_miss, output, 1, registered one-cycle pulse: ret was served from ret_target.

Function
REQ-018 Next-PC priority SHALL be: exception > eret > ret > call > jump > branch_taken > sequential (PC_o+INC).
REQ-019 An exception SHALL take effect even when PCWrite=0, setting EPC_o<=PC_o and PC_o<=EXC_VECTOR.
REQ-020 All other events SHALL be ignored when PCWrite=0, leaving PC_o, EPC_o and the RAS unchanged.
REQ-021 eret SHALL set PC_o<=EPC_o and leave EPC_o unchanged.
REQ-022 call SHALL set PC_o<=jump_target and push PC_o+INC.
REQ-023 A push onto a full RAS SHALL overwrite the oldest entry (circular wrap), and the count SHALL stay at RAS_DEPTH.
REQ-024 ret with the RAS non-empty SHALL set PC_o<=top entry, pop the entry, and set ret_miss<=0.
REQ-025 ret with the RAS empty SHALL set PC_o<=ret_target, leave the count at 0, and set ret_miss<=1 for one cycle.
REQ-026 When an event loses on priority (e.g. call with exception), it SHALL have no RAS side effect.
REQ-027 Address arithmetic SHALL be modulo 2^WIDTH; PC_o+INC wraps silently.
REQ-028 The RAS SHALL be implemented as a top pointer (log2 RAS_DEPTH bits) plus a count (0..RAS_DEPTH).
REQ-029 ras_empty SHALL equal (count==0) and ras_full SHALL equal (count==RAS_DEPTH); both are combinational from registered state.
REQ-030 ret_miss SHALL be 0 in every cycle not following a served empty-RAS ret.
REQ-031 Latency SHALL be one cycle: the selected next PC appears on PC_o after the capturing edge.

Reset
REQ-032 When reset=0, the block SHALL immediately, independent of clk, set PC_o=RESET_VECTOR, EPC_o=0, count=0, top pointer=0 and ret_miss=0.
REQ-033 Reset SHALL drive ras_empty=1 and ras_full=0.
REQ-034 Reset asserted mid-operation (e.g. during a call) SHALL discard the in-flight update.
REQ-035 Operation SHALL resume on the first rising clk edge after reset returns to 1.
REQ-036 RAS entry contents need not be cleared by reset.

Verification
REQ-037 Release reset with PCWrite=1 and no events for 3 clocks -> PC_o sequence 0, 4, 8, 12.
REQ-038 At PC_o=0x10, assert call with jump_target=0x100 -> PC_o=0x100 and ras_empty=0; then ret -> PC_o=0x14, ras_empty=1, ret_miss=0.
REQ-039 Perform 5 calls at PC_o=0x0,0x100,0x200,0x300,0x400 (RAS_DEPTH=4), then 5 rets with ret_target=0xDEAD0 -> ras_full=1 after the 4th call; returns 0x404, 0x304, 0x204, 0x104, then 0xDEAD0 with ret_miss=1 for one cycle.
REQ-040 At PC_o=0x40, hold PCWrite=0 and assert exception -> PC_o=0x80 and EPC_o=0x40; then PCWrite=1 with eret -> PC_o=0x40.
REQ-041 Assert call, ret and branch_taken together with exception -> PC_o=0x80 and the RAS count unchanged.
REQ-042 Drive reset low asynchronously between clk edges while PC_o=0x200 -> PC_o=0 before the next clk edge and ras_empty=1.
